// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the stack push/pull sequencer: FSM states, transfer
// direction and the byte selector used by the lookup and the datapath.
package stack_sequencer_pkg;

    typedef enum logic [1:0] {
        C_STACK_ST_IDLE = 2'd0,
        C_STACK_ST_XFER = 2'd1,
        C_STACK_ST_FIN  = 2'd2
    } stack_state_e;

    localparam logic C_STACK_DIR_PUSH = 1'b0;
    localparam logic C_STACK_DIR_PULL = 1'b1;

    typedef enum logic [1:0] {
        C_STACK_SEL_PCH = 2'd0,
        C_STACK_SEL_PCL = 2'd1,
        C_STACK_SEL_P   = 2'd2
    } stack_sel_e;

endpackage

// File: rtl/stack_sequencer_bytesel.sv
// Byte-order lookup: (direction, count, index) -> which byte moves this cycle.
// Pull order is the mirror of push order so a pull undoes the matching push.
module stack_sequencer_bytesel
    import stack_sequencer_pkg::*;
(
    input  logic       dir,
    input  logic [1:0] count,
    input  logic [1:0] idx,
    output stack_sel_e sel,
    output logic       last
);

    always_comb begin
        sel = C_STACK_SEL_P;
        if (dir == C_STACK_DIR_PUSH) begin
            case (count)
                2'd3: begin
                    case (idx)
                        2'd0:    sel = C_STACK_SEL_PCH;
                        2'd1:    sel = C_STACK_SEL_PCL;
                        default: sel = C_STACK_SEL_P;
                    endcase
                end
                2'd2:    sel = (idx == 2'd0) ? C_STACK_SEL_PCH : C_STACK_SEL_PCL;
                default: sel = C_STACK_SEL_P;
            endcase
        end else begin
            case (count)
                2'd3: begin
                    case (idx)
                        2'd0:    sel = C_STACK_SEL_P;
                        2'd1:    sel = C_STACK_SEL_PCL;
                        default: sel = C_STACK_SEL_PCH;
                    endcase
                end
                2'd2:    sel = (idx == 2'd0) ? C_STACK_SEL_PCL : C_STACK_SEL_PCH;
                default: sel = C_STACK_SEL_P;
            endcase
        end
    end

    assign last = (idx == (count - 2'd1));

endmodule

// File: rtl/stack_sequencer.sv
// Stack push/pull sequencer: owns SP, walks 1..3 bytes through page 1 and
// captures pulled bytes for the PC and P paths.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter logic [7:0] SP_RESET   = 8'hFD,
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        RDY,
    input  logic        START,
    input  logic        DIR,
    input  logic [1:0]  COUNT,
    input  logic [7:0]  DIN_PCH,
    input  logic [7:0]  DIN_PCL,
    input  logic [7:0]  DIN_P,
    input  logic        SP_LOAD,
    input  logic [7:0]  SP_IN,
    input  logic [7:0]  DATA_IN,
    output logic [15:0] ADDR,
    output logic [7:0]  DATA_OUT,
    output logic        WE,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  SP,
    output logic [7:0]  PCL_OUT,
    output logic [7:0]  PCH_OUT,
    output logic [7:0]  P_OUT
);

    stack_state_e state;
    logic         dir_q;
    logic [1:0]   count_q;
    logic [1:0]   idx;
    logic [7:0]   pch_q, pcl_q, p_q;
    stack_sel_e   sel;
    logic         last;

    stack_sequencer_bytesel u_bytesel (
        .dir   (dir_q),
        .count (count_q),
        .idx   (idx),
        .sel   (sel),
        .last  (last)
    );

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state   <= C_STACK_ST_IDLE;
            SP      <= SP_RESET;
            dir_q   <= C_STACK_DIR_PUSH;
            count_q <= 2'd0;
            idx     <= 2'd0;
            pch_q   <= 8'h00;
            pcl_q   <= 8'h00;
            p_q     <= 8'h00;
            PCL_OUT <= 8'h00;
            PCH_OUT <= 8'h00;
            P_OUT   <= 8'h00;
        end else begin
            case (state)
                C_STACK_ST_IDLE: begin
                    // SP_LOAD wins over START so TXS never races a stack op
                    if (RDY) begin
                        if (SP_LOAD) begin
                            SP <= SP_IN;
                        end else if (START && (COUNT != 2'd0)) begin
                            dir_q   <= DIR;
                            count_q <= COUNT;
                            pch_q   <= DIN_PCH;
                            pcl_q   <= DIN_PCL;
                            p_q     <= DIN_P;
                            idx     <= 2'd0;
                            state   <= C_STACK_ST_XFER;
                        end
                    end
                end
                C_STACK_ST_XFER: begin
                    if (RDY) begin
                        if (dir_q == C_STACK_DIR_PUSH) begin
                            SP <= SP - 8'd1;
                        end else begin
                            SP <= SP + 8'd1;
                            case (sel)
                                C_STACK_SEL_PCH: PCH_OUT <= DATA_IN;
                                C_STACK_SEL_PCL: PCL_OUT <= DATA_IN;
                                default:         P_OUT   <= DATA_IN;
                            endcase
                        end
                        idx <= idx + 2'd1;
                        if (last)
                            state <= C_STACK_ST_FIN;
                    end
                end
                C_STACK_ST_FIN: state <= C_STACK_ST_IDLE;
                default:        state <= C_STACK_ST_IDLE;
            endcase
        end
    end

    // Pulls read one above SP (pre-increment); pushes write at SP (post-decrement)
    always_comb begin
        ADDR     = {STACK_PAGE, SP};
        DATA_OUT = 8'h00;
        WE       = 1'b0;
        if (state == C_STACK_ST_XFER) begin
            if (dir_q == C_STACK_DIR_PULL) begin
                ADDR = {STACK_PAGE, SP + 8'd1};
            end else begin
                WE = RDY;
                case (sel)
                    C_STACK_SEL_PCH: DATA_OUT = pch_q;
                    C_STACK_SEL_PCL: DATA_OUT = pcl_q;
                    default:         DATA_OUT = p_q;
                endcase
            end
        end
    end

    assign BUSY = (state != C_STACK_ST_IDLE);
    assign DONE = (state == C_STACK_ST_FIN);

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: page-1 memory model, per-cycle reference model
// of the stack sequencer, and directed scenarios with literal expectations.
module tb_stack_sequencer;

    logic        CLK = 1'b0;
    logic        RES_N, RDY, START, DIR, SP_LOAD;
    logic [1:0]  COUNT;
    logic [7:0]  DIN_PCH, DIN_PCL, DIN_P, SP_IN, DATA_IN;
    logic [15:0] ADDR;
    logic [7:0]  DATA_OUT, SP, PCL_OUT, PCH_OUT, P_OUT;
    logic        WE, BUSY, DONE;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    logic [7:0]  mem [256];
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    stack_sequencer dut (
        .CLK(CLK), .RES_N(RES_N), .RDY(RDY), .START(START), .DIR(DIR),
        .COUNT(COUNT), .DIN_PCH(DIN_PCH), .DIN_PCL(DIN_PCL), .DIN_P(DIN_P),
        .SP_LOAD(SP_LOAD), .SP_IN(SP_IN), .DATA_IN(DATA_IN), .ADDR(ADDR),
        .DATA_OUT(DATA_OUT), .WE(WE), .BUSY(BUSY), .DONE(DONE), .SP(SP),
        .PCL_OUT(PCL_OUT), .PCH_OUT(PCH_OUT), .P_OUT(P_OUT)
    );

    always #5 CLK = ~CLK;

    assign DATA_IN = mem[ADDR[7:0]];

    always @(posedge CLK) begin
        if (RES_N && WE) begin
            mem[ADDR[7:0]] <= DATA_OUT;
            wr_addr.push_back(ADDR);
            wr_data.push_back(DATA_OUT);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / transferring a list of bytes / finishing.
    // For a push the list holds byte values; for a pull it holds targets
    // (0 = P, 1 = PCL, 2 = PCH).
    int         m_mode;
    logic       m_pull;
    logic [7:0] m_sp, m_pcl, m_pch, m_p;
    logic [7:0] m_q [$];

    always @(negedge CLK) begin
        logic [15:0] e_addr;
        logic        e_we;
        logic [7:0]  e_do;
        logic [7:0]  v;
        if (DONE) done_cnt++;
        if (!RES_N) begin
            m_mode = 0; m_sp = 8'hFD; m_pcl = 0; m_pch = 0; m_p = 0;
            m_q.delete();
        end
        e_addr = {8'h01, m_sp};
        e_we   = 1'b0;
        e_do   = 8'h00;
        if (m_mode == 1) begin
            if (m_pull) e_addr = {8'h01, m_sp + 8'd1};
            else begin e_we = RDY; e_do = m_q[0]; end
        end
        chk("addr",     ADDR, e_addr);
        chk("we",       16'(WE), 16'(e_we));
        chk("data_out", 16'(DATA_OUT), 16'(e_do));
        chk("busy",     16'(BUSY), 16'(m_mode != 0));
        chk("done",     16'(DONE), 16'(m_mode == 2));
        chk("sp",       16'(SP), 16'(m_sp));
        chk("pcl_out",  16'(PCL_OUT), 16'(m_pcl));
        chk("pch_out",  16'(PCH_OUT), 16'(m_pch));
        chk("p_out",    16'(P_OUT), 16'(m_p));
        if (RES_N) begin
            case (m_mode)
                0: if (RDY) begin
                    if (SP_LOAD) m_sp = SP_IN;
                    else if (START && COUNT != 0) begin
                        m_pull = DIR;
                        m_q.delete();
                        if (!DIR) begin
                            if (COUNT == 3) m_q = '{DIN_PCH, DIN_PCL, DIN_P};
                            else if (COUNT == 2) m_q = '{DIN_PCH, DIN_PCL};
                            else m_q = '{DIN_P};
                        end else begin
                            if (COUNT == 3) m_q = '{8'd0, 8'd1, 8'd2};
                            else if (COUNT == 2) m_q = '{8'd1, 8'd2};
                            else m_q = '{8'd0};
                        end
                        m_mode = 1;
                    end
                end
                1: if (RDY) begin
                    if (!m_pull) m_sp = m_sp - 8'd1;
                    else begin
                        v = mem[m_sp + 8'd1];
                        if (m_q[0] == 0) m_p = v;
                        else if (m_q[0] == 1) m_pcl = v;
                        else m_pch = v;
                        m_sp = m_sp + 8'd1;
                    end
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic start_seq(input logic d, input logic [1:0] c,
                             input logic [7:0] pch, input logic [7:0] pcl, input logic [7:0] p);
        START = 1; DIR = d; COUNT = c; DIN_PCH = pch; DIN_PCL = pcl; DIN_P = p;
        tick();
        START = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            n++;
            if (DONE) break;
        end
        chk("done_seen", 16'(DONE), 16'd1);
        tick();
    endtask

    task automatic load_sp(input logic [7:0] v);
        SP_LOAD = 1; SP_IN = v;
        tick();
        SP_LOAD = 0;
    endtask

    initial begin
        int n, d0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        RES_N = 0; RDY = 1; START = 0; DIR = 0; COUNT = 0;
        DIN_PCH = 0; DIN_PCL = 0; DIN_P = 0; SP_LOAD = 0; SP_IN = 0;
        repeat (3) tick();
        chk("rst_sp", 16'(SP), 16'h00FD);
        chk("rst_addr", ADDR, 16'h01FD);
        chk("rst_flags", 16'({WE, BUSY, DONE}), 16'd0);
        RES_N = 1;
        tick();

        // push 3
        wr_addr.delete(); wr_data.delete(); d0 = done_cnt;
        start_seq(1'b0, 2'd3, 8'h12, 8'h34, 8'hA5);
        wait_done(n);
        chk("push3_lat", 16'(n), 16'd4);
        chk("push3_sp", 16'(SP), 16'h00FA);
        chk("push3_nwr", 16'(wr_addr.size()), 16'd3);
        if (wr_addr.size() == 3) begin
            chk("push3_a0", wr_addr[0], 16'h01FD); chk("push3_d0", 16'(wr_data[0]), 16'h12);
            chk("push3_a1", wr_addr[1], 16'h01FC); chk("push3_d1", 16'(wr_data[1]), 16'h34);
            chk("push3_a2", wr_addr[2], 16'h01FB); chk("push3_d2", 16'(wr_data[2]), 16'hA5);
        end
        chk("push3_done", 16'(done_cnt - d0), 16'd1);

        // pull 3
        wr_addr.delete(); wr_data.delete();
        start_seq(1'b1, 2'd3, 8'h00, 8'h00, 8'h00);
        wait_done(n);
        chk("pull3_lat", 16'(n), 16'd4);
        chk("pull3_p", 16'(P_OUT), 16'hA5);
        chk("pull3_pcl", 16'(PCL_OUT), 16'h34);
        chk("pull3_pch", 16'(PCH_OUT), 16'h12);
        chk("pull3_sp", 16'(SP), 16'h00FD);
        chk("pull3_nwr", 16'(wr_addr.size()), 16'd0);

        // wrap-around
        load_sp(8'h00);
        chk("wrap_load", 16'(SP), 16'h0000);
        start_seq(1'b0, 2'd1, 8'h00, 8'h00, 8'h5A);
        wait_done(n);
        chk("wrap_push_lat", 16'(n), 16'd2);
        chk("wrap_push_sp", 16'(SP), 16'h00FF);
        chk("wrap_push_a", wr_addr.size() > 0 ? wr_addr[0] : 16'hFFFF, 16'h0100);
        chk("wrap_push_d", 16'(mem[0]), 16'h005A);
        start_seq(1'b1, 2'd1, 8'h00, 8'h00, 8'h00);
        chk("wrap_pull_addr", ADDR, 16'h0100);
        wait_done(n);
        chk("wrap_pull_p", 16'(P_OUT), 16'h005A);
        chk("wrap_pull_sp", 16'(SP), 16'h0000);
        chk("wrap_pull_pcl", 16'(PCL_OUT), 16'h0034);

        // RDY stall on second byte of push 2
        load_sp(8'hFD);
        wr_addr.delete(); wr_data.delete();
        start_seq(1'b0, 2'd2, 8'hAB, 8'hCD, 8'h00);
        tick();
        RDY = 0;
        chk("stall_sp0", 16'(SP), 16'h00FC);
        tick(); tick();
        chk("stall_sp1", 16'(SP), 16'h00FC);
        chk("stall_we", 16'(WE), 16'd0);
        chk("stall_addr", ADDR, 16'h01FC);
        RDY = 1;
        wait_done(n);
        chk("stall_lat", 16'(n), 16'd2);
        chk("stall_nwr", 16'(wr_addr.size()), 16'd2);
        if (wr_addr.size() == 2) begin
            chk("stall_a0", wr_addr[0], 16'h01FD); chk("stall_d0", 16'(wr_data[0]), 16'hAB);
            chk("stall_a1", wr_addr[1], 16'h01FC); chk("stall_d1", 16'(wr_data[1]), 16'hCD);
        end
        chk("stall_sp", 16'(SP), 16'h00FB);

        // COUNT 0 ignored
        start_seq(1'b0, 2'd0, 8'h11, 8'h22, 8'h33);
        chk("cnt0_busy", 16'(BUSY), 16'd0);
        chk("cnt0_sp", 16'(SP), 16'h00FB);

        // START while busy ignored
        wr_addr.delete(); wr_data.delete(); d0 = done_cnt;
        START = 1; DIR = 0; COUNT = 1; DIN_P = 8'h77;
        tick();
        DIR = 1; COUNT = 3;
        tick();
        START = 0;
        chk("busy_start_done", 16'(DONE), 16'd1);
        tick();
        chk("busy_start_idle", 16'(BUSY), 16'd0);
        chk("busy_start_nwr", 16'(wr_addr.size()), 16'd1);
        chk("busy_start_d", wr_data.size() > 0 ? 16'(wr_data[0]) : 16'hFFFF, 16'h0077);
        chk("busy_start_sp", 16'(SP), 16'h00FA);
        chk("busy_start_pulses", 16'(done_cnt - d0), 16'd1);

        // SP_LOAD beats START
        SP_LOAD = 1; SP_IN = 8'h40; START = 1; DIR = 0; COUNT = 2;
        tick();
        SP_LOAD = 0; START = 0;
        chk("ld_start_sp", 16'(SP), 16'h0040);
        chk("ld_start_busy", 16'(BUSY), 16'd0);

        // reset mid-push
        load_sp(8'h80);
        start_seq(1'b0, 2'd3, 8'h01, 8'h02, 8'h03);
        tick();
        RES_N = 0;
        #1;
        chk("midrst_sp", 16'(SP), 16'h00FD);
        chk("midrst_we", 16'(WE), 16'd0);
        chk("midrst_busy", 16'(BUSY), 16'd0);
        chk("midrst_addr", ADDR, 16'h01FD);
        tick(); tick();
        RES_N = 1;
        wr_addr.delete(); wr_data.delete();
        repeat (4) tick();
        chk("midrst_nwr", 16'(wr_addr.size()), 16'd0);
        chk("midrst_idle", 16'(BUSY), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
